// File: rtl/spatz_pkg.sv
// Shared types and constants for the Spatz vector register file.
// Addresses are {vreg, word}; data words are N_IPU*ELEN bits wide with byte enables.
package spatz_pkg;

  localparam int unsigned N_IPU        = 2;
  localparam int unsigned ELEN         = 64;
  localparam int unsigned ELENB        = ELEN / 8;
  localparam int unsigned VELE         = 4;
  localparam int unsigned NrVRegs      = 32;
  localparam int unsigned NrReadPorts  = 3;
  localparam int unsigned NrWritePorts = 2;

  localparam int unsigned VRegDataW = N_IPU * ELEN;
  localparam int unsigned VRegBeW   = N_IPU * ELENB;
  localparam int unsigned NrRows    = NrVRegs * VELE;
  localparam int unsigned RowW      = $clog2(NrRows);
  localparam int unsigned VRegW     = $clog2(NrVRegs);
  localparam int unsigned WordW     = $clog2(VELE);

  typedef logic [VRegDataW-1:0] vreg_data_t;
  typedef logic [VRegBeW-1:0]   vreg_be_t;
  typedef logic [RowW-1:0]      vreg_row_t;

  typedef struct packed {
    logic [VRegW-1:0] vreg;
    logic [WordW-1:0] word;
  } vreg_addr_t;

  typedef enum logic [0:0] {
    RrPort0 = 1'b0,
    RrPort1 = 1'b1
  } rr_ptr_e;

  function automatic vreg_row_t row_of(input vreg_addr_t addr);
    return vreg_row_t'(addr.vreg) * vreg_row_t'(VELE) + vreg_row_t'(addr.word);
  endfunction

  function automatic vreg_data_t merge_bytes(input vreg_data_t old_word,
                                             input vreg_data_t new_word,
                                             input vreg_be_t   be);
    vreg_data_t res;
    res = old_word;
    for (int b = 0; b < int'(VRegBeW); b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/spatz_vrf_write_arbiter.sv
// Two-port round-robin write arbiter for the VRF (0 = VFU, 1 = VLSU).
// The pointer only moves on a conflict, so colliding ports alternate grants.
module spatz_vrf_write_arbiter
  import spatz_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NrWritePorts-1:0] we_i,
  output logic [NrWritePorts-1:0] gnt_o
);

  rr_ptr_e rr_q, rr_d;
  logic    conflict;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_q <= RrPort0;
    else         rr_q <= rr_d;
  end

  always_comb begin
    conflict = we_i[0] & we_i[1];
    gnt_o    = we_i;
    rr_d     = rr_q;
    if (conflict) begin
      // Pointer moves to the port that just lost.
      if (rr_q == RrPort0) begin
        gnt_o = 2'b01;
        rr_d  = RrPort1;
      end else begin
        gnt_o = 2'b10;
        rr_d  = RrPort0;
      end
    end
  end

endmodule

// File: rtl/spatz_vrf.sv
// Flip-flop vector register file: 3 read ports with 1-cycle latency and
// same-cycle write bypass, 2 arbitrated byte-enabled write ports.
module spatz_vrf
  import spatz_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  vreg_addr_t              waddr_i  [NrWritePorts],
  input  vreg_data_t              wdata_i  [NrWritePorts],
  input  logic [NrWritePorts-1:0] we_i,
  input  vreg_be_t                wbe_i    [NrWritePorts],
  output logic [NrWritePorts-1:0] wvalid_o,
  input  vreg_addr_t              raddr_i  [NrReadPorts],
  input  logic [NrReadPorts-1:0]  re_i,
  output vreg_data_t              rdata_o  [NrReadPorts],
  output logic [NrReadPorts-1:0]  rvalid_o
);

  logic [NrWritePorts-1:0] gnt;
  logic                    wen;
  vreg_row_t               wrow;
  vreg_data_t              wdata_sel;
  vreg_be_t                wbe_sel;

  vreg_data_t              mem_q   [NrRows];
  vreg_data_t              rword   [NrReadPorts];
  vreg_data_t              rdata_q [NrReadPorts];
  vreg_data_t              rdata_d [NrReadPorts];
  logic [NrReadPorts-1:0]  rvalid_q, rvalid_d;

  spatz_vrf_write_arbiter i_write_arbiter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (we_i),
    .gnt_o  (gnt)
  );

  assign wvalid_o = we_i & gnt;

  always_comb begin
    wen       = |gnt;
    wrow      = row_of(waddr_i[0]);
    wdata_sel = wdata_i[0];
    wbe_sel   = wbe_i[0];
    if (gnt[1]) begin
      wrow      = row_of(waddr_i[1]);
      wdata_sel = wdata_i[1];
      wbe_sel   = wbe_i[1];
    end
  end

  // Storage is intentionally not reset; a reset cycle only suppresses the commit.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wen) mem_q[wrow] <= merge_bytes(mem_q[wrow], wdata_sel, wbe_sel);
  end

  always_comb begin
    for (int r = 0; r < int'(NrReadPorts); r++) begin
      rword[r] = mem_q[row_of(raddr_i[r])];
      if (wen && (row_of(raddr_i[r]) == wrow)) begin
        rword[r] = merge_bytes(rword[r], wdata_sel, wbe_sel);
      end
      rdata_d[r] = re_i[r] ? rword[r] : rdata_q[r];
    end
    rvalid_d = re_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      for (int r = 0; r < int'(NrReadPorts); r++) rdata_q[r] <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      for (int r = 0; r < int'(NrReadPorts); r++) rdata_q[r] <= rdata_d[r];
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_spatz_vrf.sv
// Self-checking bench for spatz_vrf: table-driven single-cycle vectors plus
// hand-written sequences for arbitration and reset behaviour.
module tb_spatz_vrf;
  import spatz_pkg::*;

  typedef struct {
    logic [1:0] we;
    vreg_addr_t waddr [2];
    vreg_data_t wdata [2];
    vreg_be_t   wbe   [2];
    logic [2:0] re;
    vreg_addr_t raddr [3];
    logic [1:0] expWvalid;
    logic [2:0] expRvalid;
    vreg_data_t expRdata [3];
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rstN;
  vreg_addr_t              waddr  [NrWritePorts];
  vreg_data_t              wdata  [NrWritePorts];
  logic [NrWritePorts-1:0] we;
  vreg_be_t                wbe    [NrWritePorts];
  logic [NrWritePorts-1:0] wvalid;
  vreg_addr_t              raddr  [NrReadPorts];
  logic [NrReadPorts-1:0]  re;
  vreg_data_t              rdata  [NrReadPorts];
  logic [NrReadPorts-1:0]  rvalid;

  int         compared   = 0;
  int         mismatched = 0;
  vreg_data_t lastExp [NrReadPorts];
  vec_t       vecs [$];

  always #5 clk = ~clk;

  spatz_vrf dut (
    .clk_i    (clk),
    .rst_ni   (rstN),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .we_i     (we),
    .wbe_i    (wbe),
    .wvalid_o (wvalid),
    .raddr_i  (raddr),
    .re_i     (re),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  function automatic vreg_addr_t A(input int v, input int w);
    vreg_addr_t a;
    a.vreg = VRegW'(v);
    a.word = WordW'(w);
    return a;
  endfunction

  function automatic vec_t blankVec();
    vec_t v;
    v.we = '0; v.re = '0; v.expWvalid = '0; v.expRvalid = '0;
    for (int p = 0; p < 2; p++) begin
      v.waddr[p] = '0; v.wdata[p] = '0; v.wbe[p] = '0;
    end
    for (int r = 0; r < 3; r++) begin
      v.raddr[r] = '0; v.expRdata[r] = '0;
    end
    return v;
  endfunction

  function automatic vec_t wr(input vec_t base, input int p, input vreg_addr_t a,
                              input vreg_data_t d, input vreg_be_t be);
    vec_t v = base;
    v.we[p] = 1'b1; v.waddr[p] = a; v.wdata[p] = d; v.wbe[p] = be;
    v.expWvalid[p] = 1'b1;
    return v;
  endfunction

  function automatic vec_t rd(input vec_t base, input int r, input vreg_addr_t a,
                              input vreg_data_t exp);
    vec_t v = base;
    v.re[r] = 1'b1; v.raddr[r] = a; v.expRvalid[r] = 1'b1; v.expRdata[r] = exp;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [VRegDataW-1:0] act,
                          input logic [VRegDataW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; re = '0;
    for (int p = 0; p < int'(NrWritePorts); p++) begin
      waddr[p] = '0; wdata[p] = '0; wbe[p] = '0;
    end
    for (int r = 0; r < int'(NrReadPorts); r++) raddr[r] = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    we = v.we; re = v.re;
    for (int p = 0; p < 2; p++) begin
      waddr[p] = v.waddr[p]; wdata[p] = v.wdata[p]; wbe[p] = v.wbe[p];
    end
    for (int r = 0; r < 3; r++) raddr[r] = v.raddr[r];
  endtask

  // Read ports without a new read must keep their previous data.
  task automatic checkOutput(input vec_t v, input string tag);
    #1;
    checkVal($sformatf("%s wvalid", tag), VRegDataW'(wvalid), VRegDataW'(v.expWvalid));
    @(posedge clk);
    #1;
    checkVal($sformatf("%s rvalid", tag), VRegDataW'(rvalid), VRegDataW'(v.expRvalid));
    for (int r = 0; r < 3; r++) begin
      if (v.expRvalid[r]) lastExp[r] = v.expRdata[r];
      checkVal($sformatf("%s rdata%0d", tag, r), rdata[r], lastExp[r]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vreg_data_t pA5, p11, pFF, p01, p02, p03, p77, pDead, pDeadLo0;
    logic [1:0] expGrant [4];
    int         cnt0, cnt1;
    vec_t       v;

    pA5      = {16{8'hA5}};
    p11      = {16{8'h11}};
    pFF      = {16{8'hFF}};
    p01      = {16{8'h01}};
    p02      = {16{8'h02}};
    p03      = {16{8'h03}};
    p77      = {16{8'h77}};
    pDead    = {8{16'hDEAD}};
    pDeadLo0 = {{4{16'hDEAD}}, 64'h0};

    vecs.push_back(wr(blankVec(), 0, A(3,1), pA5, '1));
    vecs.push_back(rd(blankVec(), 0, A(3,1), pA5));
    vecs.push_back(wr(blankVec(), 0, A(5,2), p11, '1));
    vecs.push_back(wr(blankVec(), 1, A(5,2), pFF, 16'h000F));
    vecs.push_back(rd(blankVec(), 2, A(5,2), {{12{8'h11}}, 32'hFFFF_FFFF}));
    vecs.push_back(wr(blankVec(), 0, A(1,0), p01, '1));
    vecs.push_back(wr(blankVec(), 1, A(2,0), p02, '1));
    vecs.push_back(wr(blankVec(), 0, A(3,0), p03, '1));
    vecs.push_back(rd(rd(rd(blankVec(), 0, A(1,0), p01), 1, A(2,0), p02), 2, A(3,0), p03));
    vecs.push_back(blankVec());
    vecs.push_back(wr(blankVec(), 0, A(4,3), p77, '1));
    vecs.push_back(rd(wr(blankVec(), 0, A(4,3), pDead, '1), 1, A(4,3), pDead));
    vecs.push_back(rd(wr(blankVec(), 1, A(4,3), '0, 16'h00FF), 0, A(4,3), pDeadLo0));
    vecs.push_back(rd(wr(blankVec(), 0, A(4,3), pFF, '0), 2, A(4,3), pDeadLo0));
    vecs.push_back(rd(rd(rd(blankVec(), 0, A(3,1), pA5), 1, A(3,1), pA5), 2, A(3,1), pA5));
    vecs.push_back(rd(blankVec(), 0, A(4,3), pDeadLo0));

    // Reset state
    rstN = 1'b0;
    idle();
    for (int r = 0; r < 3; r++) lastExp[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset rvalid", VRegDataW'(rvalid), '0);
    for (int r = 0; r < 3; r++) checkVal($sformatf("reset rdata%0d", r), rdata[r], '0);
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Both ports colliding for four cycles must alternate grants.
    expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
    cnt0 = 0; cnt1 = 0;
    @(negedge clk);
    we = 2'b11;
    waddr[0] = A(6,0); wdata[0] = {16{8'h60}}; wbe[0] = '1;
    waddr[1] = A(7,0); wdata[1] = {16{8'h70}}; wbe[1] = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkVal($sformatf("conflict%0d wvalid", k), VRegDataW'(wvalid), VRegDataW'(expGrant[k]));
      cnt0 += int'(wvalid[0]);
      cnt1 += int'(wvalid[1]);
      @(negedge clk);
    end
    idle();
    checkVal("conflict port0 pulses", VRegDataW'(cnt0), VRegDataW'(2));
    checkVal("conflict port1 pulses", VRegDataW'(cnt1), VRegDataW'(2));
    v = rd(rd(blankVec(), 0, A(6,0), {16{8'h60}}), 1, A(7,0), {16{8'h70}});
    applyStimulus(v);
    checkOutput(v, "conflict readback");

    // Move the pointer to port 1, then confirm an uncontested grant leaves it there.
    @(negedge clk);
    we = 2'b11;
    waddr[0] = A(8,0);  wdata[0] = {16{8'h88}}; wbe[0] = '1;
    waddr[1] = A(9,0);  wdata[1] = {16{8'h99}}; wbe[1] = '1;
    #1;
    checkVal("pre-reset conflict wvalid", VRegDataW'(wvalid), VRegDataW'(2'b01));
    @(negedge clk);
    we = 2'b10;
    #1;
    checkVal("pre-reset solo wvalid", VRegDataW'(wvalid), VRegDataW'(2'b10));
    @(negedge clk);
    idle();
    re[2] = 1'b1; raddr[2] = A(9,0);
    @(posedge clk);
    #1;
    checkVal("pre-reset rvalid", VRegDataW'(rvalid), VRegDataW'(3'b100));
    checkVal("pre-reset rdata2", rdata[2], {16{8'h99}});

    // Reset while a read and a write are in flight.
    @(negedge clk);
    rstN = 1'b0;
    re[2] = 1'b1; raddr[2] = A(8,0);
    we = 2'b01; waddr[0] = A(6,0); wdata[0] = '0; wbe[0] = '1;
    @(posedge clk);
    #1;
    checkVal("mid-read reset rvalid", VRegDataW'(rvalid), '0);
    checkVal("mid-read reset rdata2", rdata[2], '0);
    for (int r = 0; r < 3; r++) lastExp[r] = '0;
    @(negedge clk);
    rstN = 1'b1;
    idle();

    @(negedge clk);
    we = 2'b11;
    waddr[0] = A(10,0); wdata[0] = {16{8'hAA}}; wbe[0] = '1;
    waddr[1] = A(11,0); wdata[1] = {16{8'hBB}}; wbe[1] = '1;
    #1;
    checkVal("post-reset conflict wvalid", VRegDataW'(wvalid), VRegDataW'(2'b01));
    @(negedge clk);
    we = 2'b10;
    #1;
    checkVal("post-reset loser wvalid", VRegDataW'(wvalid), VRegDataW'(2'b10));
    @(negedge clk);
    idle();
    v = rd(rd(rd(blankVec(), 0, A(6,0), {16{8'h60}}), 1, A(10,0), {16{8'hAA}}),
           2, A(11,0), {16{8'hBB}});
    applyStimulus(v);
    checkOutput(v, "post-reset readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
